// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared memory-access encodings, arbiter state/owner enums and
//               the alignment helper used by the memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  // Access sizes driven by the decoder and forwarded to memory
  localparam logic [1:0] MEM_ACCESS_BYTE = 2'd0;
  localparam logic [1:0] MEM_ACCESS_HALF = 2'd1;
  localparam logic [1:0] MEM_ACCESS_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_F = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // Byte accesses are always aligned; the reserved size code is treated as aligned
  function automatic logic mem_misaligned(input logic [1:0] addr_lo, input logic [1:0] acc);
    logic mis;
    mis = 1'b0;
    case (acc)
      MEM_ACCESS_HALF: mis = addr_lo[0];
      MEM_ACCESS_WORD: mis = (addr_lo != 2'b00);
      default:         mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pick
// Description : Fetch/data winner select with data priority and a bounded
//               starvation guard for fetch (consecutive-data-win counter).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_pick #(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_idle_i,
  input  logic f_req_i,
  input  logic d_req_i,
  output logic f_win_o,
  output logic d_win_o
);

  localparam int          SW         = (MAX_DATA_STREAK > 0) ? $clog2(MAX_DATA_STREAK + 1) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

  logic [SW-1:0] streak_q;
  logic [SW-1:0] streak_d;
  logic          force_f;

  // Winner select and next streak; the streak only moves while arbitrating
  always_comb begin
    force_f  = f_req_i && (MAX_DATA_STREAK != 0) && (streak_q == STREAK_MAX);
    d_win_o  = d_req_i && !force_f;
    f_win_o  = f_req_i && !d_win_o;
    streak_d = streak_q;
    if (in_idle_i) begin
      if (!f_req_i) begin
        streak_d = '0;
      end else if (d_win_o) begin
        if (streak_q != STREAK_MAX) begin
          streak_d = streak_q + 1'b1;
        end
      end else begin
        streak_d = '0;
      end
    end
  end

  // Streak register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory port between instruction fetch (F) and
//               load/store (D). One transaction in flight, data priority,
//               misaligned data accesses rejected without a memory request.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int AW              = 32,
  parameter int DW              = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          f_req_i,
  input  logic [AW-1:0] f_addr_i,
  output logic          f_gnt_o,
  output logic          f_rvalid_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  input  logic [1:0]    d_acc_i,
  output logic          d_gnt_o,
  output logic          d_err_o,
  output logic          d_rvalid_o,
  output logic [DW-1:0] rdata_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic [1:0]    mem_acc_o,
  input  logic          mem_gnt_i,
  input  logic          mem_rvalid_i,
  input  logic [DW-1:0] mem_rdata_i
);

  arb_state_t    state_q, state_d;
  owner_t        owner_q, owner_d;
  logic          f_win, d_win;
  logic          is_d;
  logic          cur_we;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_wdata;
  logic [1:0]    cur_acc;
  logic          in_req, in_err, rv, gnt;

  mem_arb_pick #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_pick (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .in_idle_i(state_q == ST_IDLE),
    .f_req_i  (f_req_i),
    .d_req_i  (d_req_i),
    .f_win_o  (f_win),
    .d_win_o  (d_win)
  );

  // Owner's request fields; fetch is always a word read with zero write data
  always_comb begin
    is_d      = (owner_q == OWN_D);
    cur_we    = is_d ? d_we_i    : 1'b0;
    cur_addr  = is_d ? d_addr_i  : f_addr_i;
    cur_wdata = is_d ? d_wdata_i : '0;
    cur_acc   = is_d ? d_acc_i   : MEM_ACCESS_WORD;
  end

  // Next-state logic; stray mem_gnt_i/mem_rvalid_i are ignored outside their states
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      ST_IDLE: begin
        if (d_win) begin
          owner_d = OWN_D;
          state_d = mem_misaligned(d_addr_i[1:0], d_acc_i) ? ST_ERR : ST_REQ;
        end else if (f_win) begin
          owner_d = OWN_F;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_gnt_i) begin
          state_d = cur_we ? ST_IDLE : ST_RESP;
        end
      end
      ST_RESP: begin
        if (mem_rvalid_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and owner registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_F;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Output decode; everything is held at zero while reset is asserted
  always_comb begin
    in_req      = (state_q == ST_REQ)  && !rst_i;
    in_err      = (state_q == ST_ERR)  && !rst_i;
    rv          = (state_q == ST_RESP) && mem_rvalid_i && !rst_i;
    gnt         = in_req && mem_gnt_i;
    mem_req_o   = in_req;
    mem_we_o    = in_req && cur_we;
    mem_addr_o  = in_req ? cur_addr  : '0;
    mem_wdata_o = in_req ? cur_wdata : '0;
    mem_acc_o   = in_req ? cur_acc   : 2'b00;
    f_gnt_o     = gnt && !is_d;
    d_gnt_o     = (gnt && is_d) || in_err;
    d_err_o     = in_err;
    f_rvalid_o  = rv && !is_d;
    d_rvalid_o  = rv && is_d;
    rdata_o     = rv ? mem_rdata_i : '0;
  end

  // A requester must keep its request (and data fields) up while memory stalls it
  a_f_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == ST_REQ && owner_q == OWN_F && !mem_gnt_i) |=> f_req_i);
  a_d_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == ST_REQ && owner_q == OWN_D && !mem_gnt_i) |=>
      (d_req_i && $stable(d_we_i) && $stable(d_addr_i) && $stable(d_wdata_i) && $stable(d_acc_i)));

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed scoreboard bench for mem_port_arbiter. Stimulus
//               pushes expected requester pulses and memory requests; a
//               negedge monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
  import mem_pkg::*;

  localparam int K_GF = 0;  // fetch grant
  localparam int K_RF = 1;  // fetch read data
  localparam int K_GD = 2;  // data grant
  localparam int K_ED = 3;  // data grant with error
  localparam int K_RD = 4;  // data read data

  typedef struct {
    int          kind;
    logic [31:0] data;
    int          cyc;   // -1: cycle not checked
  } exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  acc;
  } mexp_t;

  logic clk = 1'b0;
  logic rst;
  logic f_req, d_req, d_we, mem_gnt, mem_rvalid;
  logic [31:0] f_addr, d_addr, d_wdata, mem_rdata;
  logic [1:0]  d_acc;
  logic f_gnt_o, f_rvalid_o, d_gnt_o, d_err_o, d_rvalid_o;
  logic mem_req_o, mem_we_o;
  logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
  logic [1:0]  mem_acc_o;

  // Second instance with strict data priority
  logic z_f_req, z_d_req, z_mem_gnt;
  logic z_f_gnt_o, z_f_rvalid_o, z_d_gnt_o, z_d_err_o, z_d_rvalid_o;
  logic z_mem_req_o, z_mem_we_o;
  logic [31:0] z_rdata_o, z_mem_addr_o, z_mem_wdata_o;
  logic [1:0]  z_mem_acc_o;
  logic z_en = 1'b0;
  int   z_fcnt = 0;
  int   z_dcnt = 0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int mem_req_cnt = 0;
  exp_t  exq[$];
  mexp_t mq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter #(.AW(32), .DW(32), .MAX_DATA_STREAK(4)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .f_req_i(f_req), .f_addr_i(f_addr), .f_gnt_o(f_gnt_o), .f_rvalid_o(f_rvalid_o),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata), .d_acc_i(d_acc),
    .d_gnt_o(d_gnt_o), .d_err_o(d_err_o), .d_rvalid_o(d_rvalid_o), .rdata_o(rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_acc_o(mem_acc_o),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .MAX_DATA_STREAK(0)) u_dut_strict (
    .clk_i(clk), .rst_i(rst),
    .f_req_i(z_f_req), .f_addr_i(32'h0000_0080), .f_gnt_o(z_f_gnt_o), .f_rvalid_o(z_f_rvalid_o),
    .d_req_i(z_d_req), .d_we_i(1'b1), .d_addr_i(32'h0000_0040), .d_wdata_i(32'h0000_0022),
    .d_acc_i(MEM_ACCESS_WORD),
    .d_gnt_o(z_d_gnt_o), .d_err_o(z_d_err_o), .d_rvalid_o(z_d_rvalid_o), .rdata_o(z_rdata_o),
    .mem_req_o(z_mem_req_o), .mem_we_o(z_mem_we_o), .mem_addr_o(z_mem_addr_o),
    .mem_wdata_o(z_mem_wdata_o), .mem_acc_o(z_mem_acc_o),
    .mem_gnt_i(z_mem_gnt), .mem_rvalid_i(1'b0), .mem_rdata_i(32'h0)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic observe(input int kind, input logic [31:0] data);
    exp_t e;
    if (exq.size() == 0) begin
      chk("unexpected_pulse_kind", kind, 99);
    end else begin
      e = exq.pop_front();
      chk("pulse_kind", kind, e.kind);
      if (e.cyc >= 0) chk("pulse_cycle", cyc, e.cyc);
      if (kind == K_RF || kind == K_RD) chk("rdata", data, e.data);
    end
  endtask

  // Monitor: compare memory-side requests and requester pulses against the queues
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req_o) begin
        mem_req_cnt++;
        if (mq.size() == 0) begin
          chk("unexpected_mem_req", 1, 0);
        end else begin
          chk("mem_we",    mem_we_o,    mq[0].we);
          chk("mem_addr",  mem_addr_o,  mq[0].addr);
          chk("mem_wdata", mem_wdata_o, mq[0].wdata);
          chk("mem_acc",   mem_acc_o,   mq[0].acc);
          if (mem_gnt) void'(mq.pop_front());
        end
      end else begin
        chk("mem_idle_zero", |{mem_we_o, mem_addr_o, mem_wdata_o, mem_acc_o}, 0);
      end
      if (f_gnt_o)    observe(K_GF, 32'h0);
      if (f_rvalid_o) observe(K_RF, rdata_o);
      if (d_gnt_o)    observe(d_err_o ? K_ED : K_GD, 32'h0);
      if (d_rvalid_o) observe(K_RD, rdata_o);
      if (d_err_o && !d_gnt_o) chk("err_without_gnt", 1, 0);
      if (!f_rvalid_o && !d_rvalid_o && rdata_o != 32'h0) chk("rdata_idle_zero", rdata_o, 0);
    end
  end

  // Monitor for the strict-priority instance
  always @(negedge clk) begin
    if (z_en) begin
      if (z_f_gnt_o) z_fcnt++;
      if (z_d_gnt_o) z_dcnt++;
      if (z_mem_req_o)
        chk("z_mem_fields", {z_mem_we_o, z_mem_addr_o, z_mem_wdata_o, z_mem_acc_o},
            {1'b1, 32'h40, 32'h22, MEM_ACCESS_WORD});
      if (z_d_err_o || z_f_rvalid_o || z_d_rvalid_o || (z_rdata_o != 32'h0))
        chk("z_side_pulse", 1, 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_p(input int kind, input logic [31:0] data, input int c);
    exq.push_back('{kind: kind, data: data, cyc: c});
  endtask

  task automatic push_m(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] acc);
    mq.push_back('{we: we, addr: addr, wdata: wdata, acc: acc});
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exq.size() != 0 || mq.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_pending", exq.size() + mq.size(), 0);
    exq.delete();
    mq.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, base, n;
    rst = 1'b1;
    f_req = 1'b0; f_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    d_acc = MEM_ACCESS_BYTE; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    z_f_req = 1'b0; z_d_req = 1'b0; z_mem_gnt = 1'b0;
    repeat (3) step();
    rst = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst_requester", {f_gnt_o, f_rvalid_o, d_gnt_o, d_err_o, d_rvalid_o}, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_mem", {mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_acc_o}, 0);
    step();

    // Fetch read, immediate grant, data one cycle later
    k = cyc;
    f_req = 1'b1; f_addr = 32'h100; mem_gnt = 1'b1;
    push_m(1'b0, 32'h100, 32'h0, MEM_ACCESS_WORD);
    push_p(K_GF, 32'h0, k + 1);
    push_p(K_RF, 32'h13, k + 2);
    step();
    step();
    f_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h13;
    step();
    mem_rvalid = 1'b0; mem_rdata = '0;
    drain(20);

    // Data store, memory stalls three cycles
    step();
    k = cyc;
    base = mem_req_cnt;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h204; d_wdata = 32'hCAFE_BABE; d_acc = MEM_ACCESS_WORD;
    mem_gnt = 1'b0;
    push_m(1'b1, 32'h204, 32'hCAFE_BABE, MEM_ACCESS_WORD);
    push_p(K_GD, 32'h0, k + 4);
    repeat (4) step();
    mem_gnt = 1'b1;
    step();
    d_req = 1'b0; d_we = 1'b0; d_wdata = '0; mem_gnt = 1'b0;
    drain(20);
    chk("store_req_cycles", mem_req_cnt - base, 4);

    // Misaligned half load is rejected, then a byte load at the same address goes through
    step();
    k = cyc;
    base = mem_req_cnt;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h301; d_acc = MEM_ACCESS_HALF;
    push_p(K_ED, 32'h0, k + 1);
    step();
    step();
    chk("misaligned_no_mem_req", mem_req_cnt - base, 0);
    d_acc = MEM_ACCESS_BYTE; mem_gnt = 1'b1;
    push_m(1'b0, 32'h301, 32'h0, MEM_ACCESS_BYTE);
    push_p(K_GD, 32'h0, k + 3);
    push_p(K_RD, 32'hAB, k + 4);
    step();
    step();
    d_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hAB;
    step();
    mem_rvalid = 1'b0; mem_rdata = '0;
    drain(20);

    // Stray rvalid/gnt in idle, stray gnt during the response wait
    step();
    mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'h77;
    step();
    mem_rvalid = 1'b0; mem_gnt = 1'b0; mem_rdata = '0;
    step();
    k = cyc;
    f_req = 1'b1; f_addr = 32'h180; mem_gnt = 1'b1;
    push_m(1'b0, 32'h180, 32'h0, MEM_ACCESS_WORD);
    push_p(K_GF, 32'h0, k + 1);
    push_p(K_RF, 32'h99, k + 4);
    step();
    step();
    f_req = 1'b0;
    step();
    step();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h99;
    step();
    mem_rvalid = 1'b0; mem_rdata = '0;
    drain(20);

    // Reset while waiting for read data; a late rvalid must not surface
    step();
    k = cyc;
    f_req = 1'b1; f_addr = 32'h1C0; mem_gnt = 1'b1;
    push_m(1'b0, 32'h1C0, 32'h0, MEM_ACCESS_WORD);
    push_p(K_GF, 32'h0, k + 1);
    step();
    step();
    f_req = 1'b0; mem_gnt = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("late_rvalid_suppressed", {f_rvalid_o, d_rvalid_o}, 0);
    chk("late_rdata_zero", rdata_o, 0);
    step();
    mem_rvalid = 1'b0; mem_rdata = '0;
    k = cyc;
    f_req = 1'b1; f_addr = 32'h1C4; mem_gnt = 1'b1;
    push_m(1'b0, 32'h1C4, 32'h0, MEM_ACCESS_WORD);
    push_p(K_GF, 32'h0, k + 1);
    push_p(K_RF, 32'h5A, k + 2);
    step();
    step();
    f_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5A;
    step();
    mem_rvalid = 1'b0; mem_rdata = '0;
    drain(20);

    // Contention with streak limit 4: D,D,D,D,F,D,D,D,D,F
    step();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        push_m(1'b1, 32'h500, 32'h1111_1111, MEM_ACCESS_WORD);
        push_p(K_GD, 32'h0, -1);
      end
      push_m(1'b0, 32'h400, 32'h0, MEM_ACCESS_WORD);
      push_p(K_GF, 32'h0, -1);
      push_p(K_RF, 32'h55, -1);
    end
    f_req = 1'b1; f_addr = 32'h400;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h500; d_wdata = 32'h1111_1111; d_acc = MEM_ACCESS_WORD;
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h55;
    n = 0;
    while (exq.size() != 0 && n < 200) begin
      step();
      n++;
    end
    f_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    chk("contention_done", n < 200, 1);
    drain(20);

    // Strict data priority: fetch never wins while data keeps requesting
    step();
    z_f_req = 1'b1; z_d_req = 1'b1; z_mem_gnt = 1'b1; z_en = 1'b1;
    repeat (40) step();
    z_en = 1'b0; z_f_req = 1'b0; z_d_req = 1'b0; z_mem_gnt = 1'b0;
    chk("strict_f_grants", z_fcnt, 0);
    chk("strict_d_grants", z_dcnt, 20);

    repeat (3) step();
    chk("final_queues_empty", exq.size() + mq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between the instruction-fetch requester (F) and the load/store data requester (D).
- Sits between the fetch/PC logic, the load/store path driven by the decoder (the MEM_ACCESS_* width and write-enable controls), and the memory.
- One transaction outstanding at a time. Data has fixed priority over fetch, with a bounded-starvation guard. Misaligned data accesses are rejected without touching memory.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_DATA_STREAK, 4, number of consecutive D grants allowed while F is pending before F must win. 0 means strict D priority.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- f_req_i  in  1  fetch request (word read); held until f_gnt_o.
- f_addr_i  in  AW  fetch address.
- f_gnt_o  out  1  fetch accepted by memory (1-cycle pulse).
- f_rvalid_o  out  1  fetch data valid (1-cycle pulse).
- d_req_i  in  1  data request; held stable with its fields until d_gnt_o.
- d_we_i  in  1  1 = store, 0 = load.
- d_addr_i  in  AW  data address.
- d_wdata_i  in  DW  store data.
- d_acc_i  in  2  access size, MEM_ACCESS_BYTE/HALF/WORD.
- d_gnt_o  out  1  data accepted or rejected (1-cycle pulse).
- d_err_o  out  1  misaligned; qualifies d_gnt_o.
- d_rvalid_o  out  1  load data valid (1-cycle pulse).
- rdata_o  out  DW  read data, shared; qualified by f_rvalid_o or d_rvalid_o.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  AW  memory address.
- mem_wdata_o  out  DW  memory write data.
- mem_acc_o  out  2  memory access size.
- mem_gnt_i  in  1  memory accepts request this cycle.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  DW  read data.

Behaviour:
- States: ST_IDLE, ST_REQ, ST_RESP, ST_ERR. Registers: state_q, owner_q (F/D), streak_q.
- Reset (rst_i=1 at an edge):
  - state_q=ST_IDLE, owner_q=F, streak_q=0.
  - All outputs 0, regardless of the current state; no pending transaction survives.
- Memory-side outputs are 0 in every state other than ST_REQ.
- ST_IDLE arbitration:
  - If d_req_i=1 and not (f_req_i=1 and MAX_DATA_STREAK!=0 and streak_q==MAX_DATA_STREAK), D wins; otherwise F wins if f_req_i=1.
  - D winner, misaligned (HALF with addr[0]=1; WORD with addr[1:0]!=0; BYTE never misaligned): go to ST_ERR. Owner is stored.
  - D winner, aligned, or F winner: go to ST_REQ. Owner is stored.
  - Streak update: on a D win with f_req_i=1, streak_q+1, saturating. On an F win, or whenever f_req_i=0 in ST_IDLE, streak_q=0.
  - mem_rvalid_i and mem_gnt_i are ignored in ST_IDLE.
- ST_REQ:
  - mem_req_o=1. mem_* fields are muxed combinationally from the owner's held inputs. For F: we=0, acc=MEM_ACCESS_WORD, wdata=0.
  - When mem_gnt_i=1: pulse the owner's gnt_o. If we=1, go to ST_IDLE; otherwise go to ST_RESP.
  - When mem_gnt_i=0: stay in ST_REQ.
- ST_RESP:
  - Wait for mem_rvalid_i=1, then pulse the owner's rvalid_o with rdata_o=mem_rdata_i (pass-through, no sign extension) and go to ST_IDLE.
  - mem_gnt_i is ignored.
- ST_ERR: d_gnt_o=1, d_err_o=1 for one cycle, then go to ST_IDLE.
- rdata_o is 0 whenever neither rvalid output is asserted.
- Latency:
  - Request visible in ST_IDLE at cycle N gives mem_req_o at N+1.
  - With immediate mem_gnt_i, gnt_o at N+1.
  - For a read with rvalid one cycle after gnt, rvalid_o at N+2.
  - Minimum spacing between back-to-back transactions is one ST_IDLE cycle.
- Simultaneous events:
  - f_req_i and d_req_i in the same ST_IDLE cycle: resolved by the arbitration rule above.
  - The loser's request stays pending.
- Requester protocol violations (dropping req before gnt) are undefined; an SVA assertion flags them.

Decomposition:
- Shared package mem_pkg holds:
  - MEM_ACCESS_BYTE/HALF/WORD (2-bit), unifying the existing constants.
  - arb_state_t enum: ST_IDLE/ST_REQ/ST_RESP/ST_ERR.
  - owner_t enum: OWN_F/OWN_D.
  - Function mem_misaligned(addr[1:0], acc).
- One sub-module, mem_arb_pick: combinational winner select plus the streak_q counter register, with clk_i/rst_i. The FSM and muxing stay in the top.

Test Plan:
- Reset: after rst_i, all outputs 0. Assert rst_i while in ST_RESP, then a late mem_rvalid_i=1 with rdata=0xDEADBEEF -> no rvalid_o pulse; state is ST_IDLE.
- F read: f_req_i, addr=0x100; memory grants immediately, rvalid next cycle with 0x00000013 -> mem_req_o at cycle 1 (addr 0x100, we=0, acc=WORD); f_gnt_o at cycle 1; f_rvalid_o and rdata_o=0x00000013 at cycle 2.
- D store with delayed gnt: d_we_i=1, addr=0x204, wdata=0xCAFEBABE, acc=WORD; mem_gnt_i low for 3 cycles -> mem_req_o held for 4 cycles with stable fields; single d_gnt_o; no d_rvalid_o; back to ST_IDLE.
- Contention: f_req_i and d_req_i both held continuously, MAX_DATA_STREAK=4, all D are stores with immediate gnt -> grant order D,D,D,D,F,D,D,D,D,F; with MAX_DATA_STREAK=0, F is never granted.
- Misalignment: D load, acc=HALF, addr=0x301 -> d_gnt_o=1 and d_err_o=1 at cycle 1; mem_req_o stays 0 throughout. Then acc=BYTE, addr=0x301 -> normal memory read.
- Stray memory signals: mem_rvalid_i pulsed in ST_IDLE, and mem_gnt_i asserted in ST_RESP -> no requester-side pulses and no state change.
